button_event: RTL and testbench
===============================

# button_event

Converts a debounced pushbutton level into single-cycle user-interface events: press, release, short click, long press and auto-repeat while held. Sits directly downstream of the pushbutton debouncer, in the same clock domain, and feeds the control FSMs that need edge events instead of levels. Holds no synchronizer: `clean` is already synchronous to `clock`.

## Interface
- `LONG_CYCLES`, default 100_000_000: hold time, in clock cycles, for a long press (1 s at 100 MHz); minimum 2.
- `REPEAT_CYCLES`, default 20_000_000: auto-repeat period after a long press (200 ms at 100 MHz); minimum 2.
- `CNT_W`, default 27: counter width; requires 2^CNT_W > max(LONG_CYCLES, REPEAT_CYCLES).
- `clock`  input  1  single system clock, rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `clean`  input  1  debounced button level; 1 = pressed.
- `press`  output  1  one-cycle pulse on a press.
- `release`  output  1  one-cycle pulse on a release.
- `short_click`  output  1  one-cycle pulse on a release that occurs before the long threshold.
- `long_press`  output  1  one-cycle pulse when the hold reaches `LONG_CYCLES`.
- `repeat`  output  1  one-cycle pulse every `REPEAT_CYCLES` after `long_press` while the button is held.
- `held`  output  1  level; 1 while in PRESSED or LONG.

## Operation
- All outputs are registered. Reset value of every output is 0. The counter resets to 0 and the state resets to LOCKOUT.
- States:
  - LOCKOUT: ignores a button that is held through reset. Goes to IDLE on the first edge that samples `clean`=0. Emits no events.
  - IDLE: on `clean`=1, go to PRESSED, pulse `press`, clear the counter.
  - PRESSED: if `clean`=0, go to IDLE and pulse `release` and `short_click`. Else if count == LONG_CYCLES-1, go to LONG, pulse `long_press`, clear the counter. Else count+1.
  - LONG: if `clean`=0, go to IDLE and pulse `release` only. Else if count == REPEAT_CYCLES-1, pulse `repeat` and clear the counter. Else count+1.
- Simultaneous release and threshold on the same edge: release wins. No `long_press` or `repeat` is emitted. `short_click` is emitted only if the state was PRESSED.
- `held` = 1 in the cycle after the edge that enters PRESSED, through the cycle of the edge that leaves LONG or PRESSED (registered with the state).
- Event pulses are mutually exclusive except the pair `release` + `short_click`.
- The counter never wraps. It is cleared on every state entry and at every repeat.
- Reset asserted mid-operation clears all outputs immediately (asynchronously) and returns to LOCKOUT. A button still held after reset generates no events until it is released and pressed again.

## Timing
- Latency from the first edge sampling `clean`=1 in IDLE to `press` high: `press` is high for the cycle following that edge (1 cycle).
- `long_press` asserts exactly LONG_CYCLES cycles after `press`.
- The first `repeat` is REPEAT_CYCLES cycles after `long_press`, then every REPEAT_CYCLES cycles.
- `release` is high for the cycle following the first edge that samples `clean`=0 in PRESSED or LONG.
- A press lasting a single sampled cycle is legal and yields `press`, then `release` + `short_click` on the next cycle.
- Back-to-back operation: IDLE re-accepts a press on the edge right after the `release` edge. There is no dead time.

## Test plan
Simulation parameters for all scenarios: LONG_CYCLES=10, REPEAT_CYCLES=4, CNT_W=5.
- Reset with `clean`=0, then `clean`=1 for 5 cycles, then 0 -> `press` pulse 1 cycle after the rise; `held` high for 5 cycles; then `release` and `short_click` together for 1 cycle; no `long_press`.
- `clean`=1 for 20 cycles -> `long_press` 10 cycles after `press`; `repeat` at +4 and +8 after `long_press`; `release` without `short_click` after the fall.
- `clean` falls on the exact edge where count == 9 in PRESSED -> `release` and `short_click` only; `long_press` never pulses.
- Hold `clean`=1 through reset deassertion for 15 cycles, release, then press again -> no events during the first hold; `press` on the second rise.
- Assert `reset` asynchronously mid-LONG (between clock edges) -> all outputs 0 immediately; no `release` afterward while `clean` stays 1.
- Two 1-cycle presses separated by 1 cycle of `clean`=0 -> two `press` pulses and two `release` + `short_click` pairs, none dropped.

Source files
------------

// File: rtl/button_event_if.sv
`default_nettype none
// ============================================================================
// Module      : button_event_if
// Description : Button level in, single-cycle UI events out.
//               master = upstream/consumer side, slave = button_event itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface button_event_if;
    // "release" and "repeat" are reserved words, hence the _ev suffix.
    logic clean;
    logic press;
    logic release_ev;
    logic short_click;
    logic long_press;
    logic repeat_ev;
    logic held;

    modport master (
        output clean,
        input  press, release_ev, short_click, long_press, repeat_ev, held
    );

    modport slave (
        input  clean,
        output press, release_ev, short_click, long_press, repeat_ev, held
    );
endinterface
`default_nettype wire

// File: rtl/button_event.sv
`default_nettype none
// ============================================================================
// Module      : button_event
// Description : Turns a debounced button level into press / release /
//               short-click / long-press / auto-repeat pulses plus a held level.
// Revision    : 1.0 - initial release
// ============================================================================
module button_event #(
    parameter int unsigned LONG_CYCLES   = 100_000_000,
    parameter int unsigned REPEAT_CYCLES = 20_000_000,
    parameter int unsigned CNT_W         = 27
) (
    input wire          clock,
    input wire          reset,
    button_event_if.slave btn
);

    localparam logic [1:0] c_LOCKOUT = 2'd0;
    localparam logic [1:0] c_IDLE    = 2'd1;
    localparam logic [1:0] c_PRESSED = 2'd2;
    localparam logic [1:0] c_LONG    = 2'd3;

    localparam logic [CNT_W-1:0] c_LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic r_press, r_release, r_short, r_long, r_repeat, r_held;
    logic w_press, w_release, w_short, w_long, w_repeat, w_held;

    // State, counter and all outputs are registered together so events align with state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= c_LOCKOUT;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_short   <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
            r_held    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_press   <= w_press;
            r_release <= w_release;
            r_short   <= w_short;
            r_long    <= w_long;
            r_repeat  <= w_repeat;
            r_held    <= w_held;
        end
    end

    // Next state and counter; a release always takes priority over a threshold hit.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_LOCKOUT: begin
                if (!btn.clean) w_state_nxt = c_IDLE;
            end
            c_IDLE: begin
                if (btn.clean) begin
                    w_state_nxt = c_PRESSED;
                    w_cnt_nxt   = '0;
                end
            end
            c_PRESSED: begin
                if (!btn.clean) begin
                    w_state_nxt = c_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_LONG_LAST) begin
                    w_state_nxt = c_LONG;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end
            end
            c_LONG: begin
                if (!btn.clean) begin
                    w_state_nxt = c_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_REP_LAST) begin
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = c_LOCKOUT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Event decode from current state and input; held follows the next state.
    always_comb begin
        w_press   = (r_state == c_IDLE) && btn.clean;
        w_release = ((r_state == c_PRESSED) || (r_state == c_LONG)) && !btn.clean;
        w_short   = (r_state == c_PRESSED) && !btn.clean;
        w_long    = (r_state == c_PRESSED) && btn.clean && (r_cnt == c_LONG_LAST);
        w_repeat  = (r_state == c_LONG) && btn.clean && (r_cnt == c_REP_LAST);
        w_held    = (w_state_nxt == c_PRESSED) || (w_state_nxt == c_LONG);
    end

    assign btn.press       = r_press;
    assign btn.release_ev  = r_release;
    assign btn.short_click = r_short;
    assign btn.long_press  = r_long;
    assign btn.repeat_ev   = r_repeat;
    assign btn.held        = r_held;

endmodule
`default_nettype wire

// File: tb/tb_button_event.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_event
// Description : Self-checking bench for button_event with a scoreboard queue
//               fed by a hold-length reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_event;

    localparam int c_LONG = 10;
    localparam int c_REP  = 4;

    localparam int c_M_LOCK = 0;
    localparam int c_M_IDLE = 1;
    localparam int c_M_HELD = 2;

    logic clock;
    logic reset;

    button_event_if bif ();

    button_event #(
        .LONG_CYCLES  (c_LONG),
        .REPEAT_CYCLES(c_REP),
        .CNT_W        (5)
    ) dut (
        .clock(clock),
        .reset(reset),
        .btn  (bif.slave)
    );

    // Observed vector: {press, release, short_click, long_press, repeat, held}
    logic [5:0] w_obs;
    assign w_obs = {bif.press, bif.release_ev, bif.short_click,
                    bif.long_press, bif.repeat_ev, bif.held};

    int n_checks = 0;
    int n_errors = 0;

    logic [5:0] sb[$];
    int m_mode = c_M_LOCK;
    int m_k    = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: tracks edges since the press edge instead of a counter.
    task automatic model_edge(input bit c, output logic [5:0] e);
        e = 6'b0;
        case (m_mode)
            c_M_LOCK: if (!c) m_mode = c_M_IDLE;
            c_M_IDLE: begin
                if (c) begin
                    e[5]   = 1'b1;
                    e[0]   = 1'b1;
                    m_mode = c_M_HELD;
                    m_k    = 0;
                end
            end
            default: begin
                m_k = m_k + 1;
                if (!c) begin
                    e[4]   = 1'b1;
                    e[3]   = (m_k <= c_LONG);
                    m_mode = c_M_IDLE;
                end else begin
                    e[0] = 1'b1;
                    if (m_k == c_LONG)
                        e[2] = 1'b1;
                    else if (m_k > c_LONG && ((m_k - c_LONG) % c_REP) == 0)
                        e[1] = 1'b1;
                end
            end
        endcase
    endtask

    // Drive clean for one edge, push the expected outputs, sample 1 time unit later.
    task automatic step(input bit c);
        logic [5:0] e;
        bif.clean = c;
        @(posedge clock);
        model_edge(c, e);
        sb.push_back(e);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        m_mode = c_M_LOCK;
        m_k    = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bif.clean = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if (w_obs !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_state got %b want %b", w_obs, 6'b0);
        end
        reset = 1'b0;
        m_mode = c_M_LOCK;
    endtask

    task automatic test_short_click();
        logic [5:0] exp;
        for (int i = 0; i < 9; i++) begin
            step((i >= 2 && i < 7) ? 1'b1 : 1'b0);
            exp = sb.pop_front();
            n_checks++;
            if (w_obs !== exp) begin
                n_errors++;
                $display("FAIL short_click cyc %0d got %b want %b", i, w_obs, exp);
            end
        end
    endtask

    task automatic test_long_repeat();
        logic [5:0] exp;
        for (int i = 0; i < 24; i++) begin
            step((i >= 1 && i < 21) ? 1'b1 : 1'b0);
            exp = sb.pop_front();
            n_checks++;
            if (w_obs !== exp) begin
                n_errors++;
                $display("FAIL long_repeat cyc %0d got %b want %b", i, w_obs, exp);
            end
        end
    endtask

    task automatic test_threshold_release();
        logic [5:0] exp;
        for (int i = 0; i < 14; i++) begin
            step((i >= 1 && i < 11) ? 1'b1 : 1'b0);
            exp = sb.pop_front();
            n_checks++;
            if (w_obs !== exp) begin
                n_errors++;
                $display("FAIL threshold_release cyc %0d got %b want %b", i, w_obs, exp);
            end
        end
    endtask

    task automatic test_held_through_reset();
        logic [5:0] exp;
        bif.clean = 1'b1;
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            step((i < 15 || i == 17) ? 1'b1 : 1'b0);
            exp = sb.pop_front();
            n_checks++;
            if (w_obs !== exp) begin
                n_errors++;
                $display("FAIL held_through_reset cyc %0d got %b want %b", i, w_obs, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [5:0] exp;
        for (int i = 0; i < 14; i++) begin
            step((i >= 1) ? 1'b1 : 1'b0);
            exp = sb.pop_front();
            n_checks++;
            if (w_obs !== exp) begin
                n_errors++;
                $display("FAIL async_pre cyc %0d got %b want %b", i, w_obs, exp);
            end
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (w_obs !== 6'b0) begin
            n_errors++;
            $display("FAIL async_reset_immediate got %b want %b", w_obs, 6'b0);
        end
        m_mode = c_M_LOCK;
        m_k    = 0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step((i < 6 || i == 7) ? 1'b1 : 1'b0);
            exp = sb.pop_front();
            n_checks++;
            if (w_obs !== exp) begin
                n_errors++;
                $display("FAIL async_post cyc %0d got %b want %b", i, w_obs, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp;
        int n_press;
        int n_pair;
        n_press = 0;
        n_pair  = 0;
        for (int i = 0; i < 6; i++) begin
            step((i == 1 || i == 3) ? 1'b1 : 1'b0);
            exp = sb.pop_front();
            if (w_obs[5]) n_press++;
            if (w_obs[4] && w_obs[3]) n_pair++;
            n_checks++;
            if (w_obs !== exp) begin
                n_errors++;
                $display("FAIL back_to_back cyc %0d got %b want %b", i, w_obs, exp);
            end
        end
        n_checks++;
        if (n_press != 2 || n_pair != 2) begin
            n_errors++;
            $display("FAIL back_to_back_count got press=%0d pairs=%0d want 2/2", n_press, n_pair);
        end
    endtask

    initial begin
        reset     = 1'b1;
        bif.clean = 1'b0;
        test_reset();
        test_short_click();
        test_long_repeat();
        test_threshold_release();
        test_held_through_reset();
        test_async_reset();
        test_back_to_back();
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain got %0d entries want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
